// File: rtl/usb_tx_line_encoder_pkg.sv
// Shared constants and state encoding for the USB transmit line encoder.
package usb_tx_line_encoder_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam int         STUFF_LEN    = 6;
    localparam int         EOP_SE0_BITS = 2;
    localparam int         ONES_W       = $clog2(STUFF_LEN + 1);
    localparam int         SE0_CNT_W    = $clog2(EOP_SE0_BITS + 1);
    localparam logic [1:0] LINE_SE0     = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

endpackage

// File: rtl/usb_tx_line_encoder_bit_stuffer.sv
// Ones counter and NRZI toggle decision for the transmit bit stream.
module usb_tx_bit_stuffer
    import usb_tx_line_encoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic data_step,
    input  logic stuff_step,
    input  logic bit_in,
    input  logic is_k,
    output logic is_k_next,
    output logic stuff_req
);

    logic [ONES_W-1:0] ones_q;
    logic [ONES_W-1:0] ones_d;

    always_comb begin
        ones_d = ones_q;
        if (clear || stuff_step) begin
            ones_d = '0;
        end else if (data_step) begin
            ones_d = bit_in ? ones_q + ONES_W'(1) : '0;
        end
    end

    // A stuff bit is owed when this data bit is the STUFF_LEN-th consecutive one.
    assign stuff_req = data_step & bit_in & (ones_q == ONES_W'(STUFF_LEN - 1));
    assign is_k_next = is_k ^ (stuff_step | (data_step & ~bit_in));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line stage: SYNC, NRZI, bit stuffing, EOP and output enable,
// with every line change paced by the bit-rate strobe.
module usb_tx_line_encoder
    import usb_tx_line_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bitEn,
    input  logic [1:0] JBit,
    input  logic [1:0] KBit,
    input  logic       txStart,
    input  logic [7:0] txDataIn,
    input  logic       txDataLast,
    input  logic       txDataValid,
    output logic       txDataReady,
    output logic [1:0] usbWireData,
    output logic       usbWireOE,
    output logic       txBusy,
    output logic       txUnderrun
);

    tx_state_e            state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 last_q, last_d;
    logic                 eop_after_stuff_q, eop_after_stuff_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_last_q, hold_last_d;
    logic                 hold_full_q, hold_full_d;
    logic                 se0_q, se0_d;
    logic                 is_k_q, is_k_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic                 underrun_q, underrun_d;
    logic [SE0_CNT_W-1:0] se0_cnt_q, se0_cnt_d;

    logic accept;
    logic data_step;
    logic stuff_step;
    logic ones_clear;
    logic is_k_next;
    logic stuff_req;

    usb_tx_bit_stuffer u_stuffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (ones_clear),
        .data_step (data_step),
        .stuff_step(stuff_step),
        .bit_in    (shift_q[0]),
        .is_k      (is_k_q),
        .is_k_next (is_k_next),
        .stuff_req (stuff_req)
    );

    assign txDataReady = busy_q && !hold_full_q && (state_q == ST_DATA || state_q == ST_STUFF);
    assign accept      = txDataValid && txDataReady;

    always_comb begin
        state_d           = state_q;
        shift_d           = shift_q;
        bit_cnt_d         = bit_cnt_q;
        last_d            = last_q;
        eop_after_stuff_d = eop_after_stuff_q;
        hold_d            = hold_q;
        hold_last_d       = hold_last_q;
        hold_full_d       = hold_full_q;
        se0_d             = se0_q;
        is_k_d            = is_k_q;
        oe_d              = oe_q;
        busy_d            = busy_q;
        underrun_d        = 1'b0;
        se0_cnt_d         = se0_cnt_q;
        data_step         = 1'b0;
        stuff_step        = 1'b0;
        ones_clear        = 1'b0;

        if (accept) begin
            hold_d      = txDataIn;
            hold_last_d = txDataLast;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (txStart) begin
                    shift_d           = SYNC_BYTE;
                    bit_cnt_d         = '0;
                    last_d            = 1'b0;
                    eop_after_stuff_d = 1'b0;
                    se0_cnt_d         = '0;
                    busy_d            = 1'b1;
                    ones_clear        = 1'b1;
                    state_d           = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bitEn) begin
                    data_step = 1'b1;
                    oe_d      = 1'b1;
                    is_k_d    = is_k_next;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (stuff_req) begin
                        state_d = ST_STUFF;
                    end
                    if (bit_cnt_q == 3'd7) begin
                        // A byte handed over on this very edge is loaded directly.
                        if (hold_full_q || accept) begin
                            shift_d     = hold_full_q ? hold_q : txDataIn;
                            last_d      = hold_full_q ? hold_last_q : txDataLast;
                            hold_full_d = 1'b0;
                        end else if (last_q) begin
                            eop_after_stuff_d = stuff_req;
                            if (!stuff_req) begin
                                state_d = ST_EOP_SE0;
                            end
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = ST_EOP_SE0;
                        end
                    end
                end
            end
            ST_STUFF: begin
                if (bitEn) begin
                    stuff_step = 1'b1;
                    is_k_d     = is_k_next;
                    state_d    = eop_after_stuff_q ? ST_EOP_SE0 : ST_DATA;
                end
            end
            ST_EOP_SE0: begin
                if (bitEn) begin
                    if (se0_cnt_q == SE0_CNT_W'(EOP_SE0_BITS)) begin
                        se0_d   = 1'b0;
                        is_k_d  = 1'b0;
                        state_d = ST_EOP_J;
                    end else begin
                        se0_d     = 1'b1;
                        se0_cnt_d = se0_cnt_q + SE0_CNT_W'(1);
                    end
                end
            end
            ST_EOP_J: begin
                if (bitEn) begin
                    oe_d        = 1'b0;
                    busy_d      = 1'b0;
                    hold_full_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_IDLE;
            shift_q           <= '0;
            bit_cnt_q         <= '0;
            last_q            <= 1'b0;
            eop_after_stuff_q <= 1'b0;
            hold_q            <= '0;
            hold_last_q       <= 1'b0;
            hold_full_q       <= 1'b0;
            se0_q             <= 1'b0;
            is_k_q            <= 1'b0;
            oe_q              <= 1'b0;
            busy_q            <= 1'b0;
            underrun_q        <= 1'b0;
            se0_cnt_q         <= '0;
        end else begin
            state_q           <= state_d;
            shift_q           <= shift_d;
            bit_cnt_q         <= bit_cnt_d;
            last_q            <= last_d;
            eop_after_stuff_q <= eop_after_stuff_d;
            hold_q            <= hold_d;
            hold_last_q       <= hold_last_d;
            hold_full_q       <= hold_full_d;
            se0_q             <= se0_d;
            is_k_q            <= is_k_d;
            oe_q              <= oe_d;
            busy_q            <= busy_d;
            underrun_q        <= underrun_d;
            se0_cnt_q         <= se0_cnt_d;
        end
    end

    assign usbWireData = se0_q ? LINE_SE0 : (is_k_q ? KBit : JBit);
    assign usbWireOE   = oe_q;
    assign txBusy      = busy_q;
    assign txUnderrun  = underrun_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: expected line codes are queued at
// packet start and checked on every bit strobe.
module tb_usb_tx_line_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bitEn = 1'b0;
    logic [1:0] JBit = 2'b10;
    logic [1:0] KBit = 2'b01;
    logic       txStart = 1'b0;
    logic [7:0] txDataIn = 8'h00;
    logic       txDataLast = 1'b0;
    logic       txDataValid = 1'b0;
    logic       txDataReady;
    logic [1:0] usbWireData;
    logic       usbWireOE;
    logic       txBusy;
    logic       txUnderrun;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;
    bit         mon_en = 1'b0;
    bit         bit_gate = 1'b1;
    int         oe_bits = 0;
    int         under_cnt = 0;
    int         gen_cnt = 0;

    usb_tx_line_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .bitEn      (bitEn),
        .JBit       (JBit),
        .KBit       (KBit),
        .txStart    (txStart),
        .txDataIn   (txDataIn),
        .txDataLast (txDataLast),
        .txDataValid(txDataValid),
        .txDataReady(txDataReady),
        .usbWireData(usbWireData),
        .usbWireOE  (usbWireOE),
        .txBusy     (txBusy),
        .txUnderrun (txUnderrun)
    );

    always #5 clk = ~clk;

    // Bit strobe: one cycle in four, changed 3 time units after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            gen_cnt = gen_cnt + 1;
            bitEn = bit_gate && (gen_cnt % 4 == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (bitEn && mon_en) begin
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("bit_oe", {7'b0, usbWireOE}, 8'd1);
                check("bit_wire", {6'b0, usbWireData}, {6'b0, mon_e});
                if (usbWireOE) oe_bits++;
            end else begin
                check("idle_oe", {7'b0, usbWireOE}, 8'd0);
                check("idle_busy", {7'b0, txBusy}, 8'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (txUnderrun) under_cnt <= under_cnt + 1;
    end

    // Reference USB transmit stream: SYNC then data LSB first, NRZI, stuffing, EOP.
    task automatic push_packet(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] seq [3];
        bit k;
        int ones;
        seq[0] = 8'h80;
        seq[1] = b0;
        seq[2] = b1;
        k = 1'b0;
        ones = 0;
        for (int i = 0; i <= n; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (seq[i][j]) begin
                    ones++;
                end else begin
                    k = !k;
                    ones = 0;
                end
                exp_q.push_back(k ? KBit : JBit);
                if (ones == 6) begin
                    k = !k;
                    ones = 0;
                    exp_q.push_back(k ? KBit : JBit);
                end
            end
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(JBit);
    endtask

    task automatic start_packet(input logic [7:0] b0, input logic [7:0] b1, input int n);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bitEn && g < 50);
        check("start_strobe_seen", {7'b0, bitEn}, 8'd1);
        @(negedge clk);
        oe_bits = 0;
        push_packet(b0, b1, n);
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, output bit ok);
        @(negedge clk);
        txDataIn = d;
        txDataLast = last;
        txDataValid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (txDataReady) ok = 1'b1;
            @(negedge clk);
        end
        txDataValid = 1'b0;
    endtask

    task automatic wait_done(input int exp_bits, input int exp_under);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!txBusy && exp_q.size() == 0) break;
        end
        check("done_busy", {7'b0, txBusy}, 8'd0);
        check("done_queue_empty", 8'(exp_q.size()), 8'd0);
        repeat (10) @(negedge clk);
        check("oe_bit_times", 8'(oe_bits), 8'(exp_bits));
        check("underrun_count", 8'(under_cnt), 8'(exp_under));
    endtask

    initial begin
        bit ok;
        logic [1:0] snap_wire;
        int g;

        repeat (3) @(negedge clk);
        check("rst_oe", {7'b0, usbWireOE}, 8'd0);
        check("rst_busy", {7'b0, txBusy}, 8'd0);
        check("rst_ready", {7'b0, txDataReady}, 8'd0);
        check("rst_underrun", {7'b0, txUnderrun}, 8'd0);
        check("rst_wire", {6'b0, usbWireData}, 8'h02);
        rst = 1'b1;
        mon_en = 1'b1;

        // Byte offered while idle must not be taken.
        @(negedge clk);
        txDataIn = 8'h55;
        txDataValid = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_ready", {7'b0, txDataReady}, 8'd0);
        check("idle_offer_busy", {7'b0, txBusy}, 8'd0);
        txDataValid = 1'b0;

        start_packet(8'h00, 8'h00, 1);
        send_byte(8'h00, 1'b1, ok);
        check("fs00_accept", {7'b0, ok}, 8'd1);
        wait_done(19, 0);

        start_packet(8'hFF, 8'h00, 1);
        send_byte(8'hFF, 1'b1, ok);
        check("ffff_accept", {7'b0, ok}, 8'd1);
        repeat (20) @(negedge clk);
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        wait_done(20, 0);

        start_packet(8'hFC, 8'h00, 1);
        send_byte(8'hFC, 1'b1, ok);
        check("fc_accept", {7'b0, ok}, 8'd1);
        wait_done(20, 0);

        // Second byte never offered: truncated packet.
        start_packet(8'h00, 8'h00, 1);
        send_byte(8'h00, 1'b0, ok);
        check("underrun_accept", {7'b0, ok}, 8'd1);
        wait_done(19, 1);

        JBit = 2'b01;
        KBit = 2'b10;
        start_packet(8'h00, 8'h00, 1);
        send_byte(8'h00, 1'b1, ok);
        check("ls00_accept", {7'b0, ok}, 8'd1);
        wait_done(19, 1);

        start_packet(8'hA5, 8'h00, 1);
        send_byte(8'hA5, 1'b1, ok);
        g = 0;
        while (oe_bits < 12 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("midreset_reached", {7'b0, usbWireOE}, 8'd1);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset_oe", {7'b0, usbWireOE}, 8'd0);
        check("midreset_wire", {6'b0, usbWireData}, {6'b0, JBit});
        check("midreset_busy", {7'b0, txBusy}, 8'd0);
        check("midreset_ready", {7'b0, txDataReady}, 8'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        start_packet(8'h3C, 8'h00, 1);
        send_byte(8'h3C, 1'b1, ok);
        check("postreset_accept", {7'b0, ok}, 8'd1);
        wait_done(19, 1);

        JBit = 2'b10;
        KBit = 2'b01;
        start_packet(8'h5A, 8'h33, 2);
        send_byte(8'h5A, 1'b0, ok);
        check("freeze_b0_accept", {7'b0, ok}, 8'd1);
        g = 0;
        while (oe_bits < 11 && g < 500) begin
            @(negedge clk);
            g++;
        end
        bit_gate = 1'b0;
        repeat (3) @(negedge clk);
        snap_wire = usbWireData;
        send_byte(8'h33, 1'b1, ok);
        check("freeze_b1_accept", {7'b0, ok}, 8'd1);
        check("freeze_hold_full", {7'b0, txDataReady}, 8'd0);
        repeat (50) @(negedge clk);
        check("freeze_wire", {6'b0, usbWireData}, {6'b0, snap_wire});
        check("freeze_oe", {7'b0, usbWireOE}, 8'd1);
        check("freeze_busy", {7'b0, txBusy}, 8'd1);
        bit_gate = 1'b1;
        wait_done(27, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_line_encoder.md
Name: usb_tx_line_encoder

Overview:
- Transmit line stage of the serial interface engine. It sits directly downstream of the J/K line-control block and consumes its JBit/KBit codes.
- Takes a byte stream from the transmit packet processor and drives the USB differential pair. It generates the SYNC byte, LSB-first NRZI encoding, bit stuffing, EOP (SE0, SE0, J) and output enable.
- All line changes are paced by a one-cycle bit-rate strobe from the bit-rate divider, so one RTL serves both full speed and low speed.

Parameters:
- SYNC_BYTE, 8'h80, byte sent before packet data.
- STUFF_LEN, 6, consecutive 1s after which a stuffed 0 is inserted.
- EOP_SE0_BITS, 2, number of SE0 bit times in EOP.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- bitEn  input  1  one-cycle strobe per USB bit time.
- JBit  input  2  line code for J, from the line-control block.
- KBit  input  2  line code for K, from the line-control block.
- txStart  input  1  request to start a packet; sampled only in IDLE.
- txDataIn  input  8  packet byte.
- txDataLast  input  1  qualifies txDataIn as the final byte.
- txDataValid  input  1  byte offered.
- txDataReady  output  1  holding register empty; a byte is accepted when valid && ready.
- usbWireData  output  2  line code: 2'b00 = SE0, else JBit or KBit.
- usbWireOE  output  1  transceiver output enable.
- txBusy  output  1  high from txStart acceptance until EOP completes.
- txUnderrun  output  1  one-cycle pulse on data underrun.

Behaviour:
- Line state register {se0, isK}. usbWireData = se0 ? 2'b00 : (isK ? KBit : JBit), decoded combinationally. JBit/KBit may change only while txBusy = 0.
- Reset values: se0 = 0, isK = 0 (wire = JBit), usbWireOE = 0, txBusy = 0, txUnderrun = 0, txDataReady = 0, holding register empty, FSM = IDLE.
- States:
  - IDLE: wire = J, OE = 0, txDataReady = 0. txStart → load shifter with SYNC_BYTE, bitCnt = 0, onesCnt = 0, txBusy = 1, go to DATA.
  - txDataReady = !holdFull while txBusy and FSM is in DATA or STUFF.
  - DATA: on each bitEn, usbWireOE = 1 and send the shifter LSB.
    - Bit 0 toggles isK; bit 1 holds isK.
    - Ones counter increments on 1, clears on 0.
    - If onesCnt reaches STUFF_LEN, go to STUFF next.
  - After the 8th bit of a byte (same bitEn edge), reload the shifter:
    - holdFull → load hold byte, clear hold, lastFlag = its txDataLast.
    - Else if the current byte was last → EOP_SE0, provided no stuff bit is pending.
    - Else → txUnderrun pulse, go to EOP_SE0 (truncated packet).
  - STUFF: on bitEn, toggle isK, onesCnt = 0, consume no data bit. Then return to DATA, or go to EOP_SE0 if the pending stuff followed the last bit of the last byte.
  - EOP_SE0: se0 = 1 for EOP_SE0_BITS bitEn strobes.
  - EOP_J: se0 = 0, isK = 0 for one bitEn. On the next bitEn, OE = 0, txBusy = 0, go to IDLE.
- Latency: the first SYNC bit appears on the first bitEn after the cycle txStart is sampled.
- Boundary conditions:
  - SYNC goes through the same shifter and stuffing logic, so it ends with onesCnt = 1.
  - txStart while busy is ignored.
  - A byte offered in IDLE is not accepted.
  - Without bitEn, nothing on the wire changes. Hold accept is independent of bitEn.
  - Async reset at any time returns to IDLE, OE = 0 within the same cycle, and drops any held byte.

Decomposition:
- Shared package: state encoding, SE0 code 2'b00, SYNC/EOP constants.
- One natural sub-module, usb_tx_bit_stuffer: ones counter plus NRZI toggle logic, interfaced by bit-in/stuff-req/isK.

Test Plan:
- Full-speed polarity (J=10, K=01), one byte 0x00 last → K J K J K J K K, J K J K J K J K, SE0 SE0 J; OE high for exactly 19 bit times, then txBusy = 0.
- Byte 0xFF last → after SYNC, K K K K K, then stuffed J, then J J J, SE0 SE0 J; 20 bit times total.
- Two bytes, second not offered before the first finishes → txUnderrun pulses once, EOP follows immediately, OE low after the J bit.
- Low-speed polarity (J=01, K=10), byte 0x00 → same sequence with swapped codes; SE0 is still 00.
- rst low mid-data → OE = 0, wire = JBit, txBusy = 0 immediately. A new txStart after release sends a clean SYNC.
- bitEn held low for 50 cycles mid-byte → wire frozen, byte handshake still completes, sequence resumes intact.
